// File: rtl/key_expand_seq.sv
// rtl/key_expand_seq.sv - AES-128 round-key sequencer emitting keys 0..10 over a valid/ready handshake
//
// aes_sbox       : AES forward S-box, one byte in, one byte out (combinational)
// aes_rcon       : round constant for round-key index rnd (0 -> 01000000 ... 9 -> 36000000)
// key_expand_seq : top level
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   begin expanding key_in (honoured only in IDLE)
//   key_in   in   LENGTH-bit cipher key, w0 in the top word
//   rk_ready in   consumer accepts the current round key
//   rk_valid out  rk_out/rk_idx hold a valid round key
//   rk_out   out  current round key, same word order as key_in
//   rk_idx   out  index of the current round key, 0..10
//   busy     out  high while expanding
//   done     out  one-cycle pulse after round key 10 is accepted

module aes_sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  assign inv = gf_inv(in);
  // Affine step: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  assign out = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_rcon (
  input  logic [3:0]  rnd,
  output logic [31:0] rcon
);
  always_comb begin
    rcon = 32'h0;
    case (rnd)
      4'd0: rcon = 32'h01000000;
      4'd1: rcon = 32'h02000000;
      4'd2: rcon = 32'h04000000;
      4'd3: rcon = 32'h08000000;
      4'd4: rcon = 32'h10000000;
      4'd5: rcon = 32'h20000000;
      4'd6: rcon = 32'h40000000;
      4'd7: rcon = 32'h80000000;
      4'd8: rcon = 32'h1b000000;
      4'd9: rcon = 32'h36000000;
      default: rcon = 32'h0;
    endcase
  end
endmodule

module key_expand_seq #(
  parameter int BYTE   = 8,
  parameter int DWORD  = 32,
  parameter int LENGTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] key_in,
  input  logic              rk_ready,
  output logic              rk_valid,
  output logic [LENGTH-1:0] rk_out,
  output logic [3:0]        rk_idx,
  output logic              busy,
  output logic              done
);
  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t state;
  state_t state_next;
  logic   load;
  logic   advance;
  logic   finish;

  logic [DWORD-1:0]  w0, w1, w2, w3;
  logic [DWORD-1:0]  rot, sub, rcon, t;
  logic [DWORD-1:0]  n0, n1, n2, n3;
  logic [LENGTH-1:0] next_key;

  assign w0 = rk_out[LENGTH-1         -: DWORD];
  assign w1 = rk_out[LENGTH-1-DWORD   -: DWORD];
  assign w2 = rk_out[LENGTH-1-2*DWORD -: DWORD];
  assign w3 = rk_out[DWORD-1:0];

  assign rot = {w3[DWORD-BYTE-1:0], w3[DWORD-1 -: BYTE]};

  for (genvar g = 0; g < DWORD / BYTE; g++) begin : g_sub
    aes_sbox u_sbox (
      .in  (rot[g*BYTE +: BYTE]),
      .out (sub[g*BYTE +: BYTE])
    );
  end

  // Rcon is indexed by the key currently held: index k produces key k+1.
  aes_rcon u_rcon (
    .rnd  (rk_idx),
    .rcon (rcon)
  );

  assign t        = sub ^ rcon;
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign rk_valid = (state == EXPAND);
  assign busy     = (state == EXPAND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (rk_ready) begin
          if (rk_idx == 4'd10) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // rk_out/rk_idx keep key 10 in IDLE; only a new start or reset overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_out <= '0;
      rk_idx <= 4'd0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        rk_out <= key_in;
        rk_idx <= 4'd0;
      end else if (advance) begin
        rk_out <= next_key;
        rk_idx <= rk_idx + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_key_expand_seq.sv
// tb/tb_key_expand_seq.sv - self-checking bench for key_expand_seq against a word-level AES key schedule model
module tb_key_expand_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk   [11];

  key_expand_seq #(.BYTE(8), .DWORD(32), .LENGTH(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  // S-box built by brute-force inverse search and the bitwise affine rule.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = b;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = ref_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Entered at a falling edge in the cycle key 0 should be valid; leaves at the falling edge of the done cycle.
  task automatic drain(input int ready_pct, input bit noise, input bit hold_next, input logic [127:0] next_key);
    int k   = 0;
    int cyc = 0;
    bit rdy;
    while (k <= 10 && cyc < 400) begin
      total++;
      if (rk_valid !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL valid_busy k=%0d: got valid=%b busy=%b want 1 1", k, rk_valid, busy);
      end
      total++;
      if (rk_idx !== 4'(k)) begin
        bad++;
        $display("FAIL rk_idx: got %0d want %0d", rk_idx, k);
      end
      total++;
      if (rk_out !== exp_rk[k]) begin
        bad++;
        $display("FAIL rk_out k=%0d: got %h want %h", k, rk_out, exp_rk[k]);
      end
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL done_early k=%0d: got %b want 0", k, done);
      end
      rdy      = ($urandom_range(99) < 32'(ready_pct));
      rk_ready = rdy;
      if (noise) begin
        start  = 1'($urandom_range(1));
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (hold_next) begin
        start  = 1'b1;
        key_in = next_key;
      end
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    total++;
    if (k <= 10) begin
      bad++;
      $display("FAIL drain_timeout: got k=%0d want 11", k);
    end
    if (!hold_next) start = 1'b0;
    total++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle: got done=%b valid=%b busy=%b want 1 0 0", done, rk_valid, busy);
    end
    total++;
    if (rk_idx !== 4'd10 || rk_out !== exp_rk[10]) begin
      bad++;
      $display("FAIL retain_at_done: got idx=%0d out=%h want 10 %h", rk_idx, rk_out, exp_rk[10]);
    end
  endtask

  task automatic launch(input logic [127:0] key);
    model_expand(key);
    start  = 1'b1;
    key_in = key;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Called at the done cycle: checks the pulse drops and IDLE keeps key 10 even with rk_ready toggling.
  task automatic check_idle_after();
    for (int i = 0; i < 3; i++) begin
      rk_ready = 1'(i % 2);
      @(negedge clk);
      total++;
      if (done !== 1'b0 || rk_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_flags: got done=%b valid=%b busy=%b want 0 0 0", done, rk_valid, busy);
      end
      total++;
      if (rk_idx !== 4'd10 || rk_out !== exp_rk[10]) begin
        bad++;
        $display("FAIL idle_retain: got idx=%0d out=%h want 10 %h", rk_idx, rk_out, exp_rk[10]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    #3;
    total++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_idx !== 4'd0 || rk_out !== 128'h0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b busy=%b done=%b idx=%0d out=%h want all 0", rk_valid, busy, done, rk_idx, rk_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips();
    launch(128'h2b7e151628aed2a6abf7158809cf4f3c);
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    drain(100, 1'b0, 1'b0, '0);
    check_idle_after();
  endtask

  task automatic test_zero_key();
    launch(128'h0);
    exp_rk[1] = 128'h62636363626363636263636362636363;
    drain(100, 1'b0, 1'b0, '0);
    check_idle_after();
  endtask

  task automatic test_stall();
    launch(128'h2b7e151628aed2a6abf7158809cf4f3c);
    drain(40, 1'b0, 1'b0, '0);
    check_idle_after();
    for (int n = 0; n < 3; n++) begin
      launch({$urandom, $urandom, $urandom, $urandom});
      drain(50, 1'b0, 1'b0, '0);
      check_idle_after();
    end
  endtask

  task automatic test_start_ignored();
    launch({$urandom, $urandom, $urandom, $urandom});
    drain(60, 1'b1, 1'b0, '0);
    check_idle_after();
  endtask

  task automatic test_reset_mid();
    logic [127:0] nk;
    launch({$urandom, $urandom, $urandom, $urandom});
    rk_ready = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (rk_idx !== 4'd5 || rk_out !== exp_rk[5]) begin
      bad++;
      $display("FAIL mid_idx5: got idx=%0d out=%h want 5 %h", rk_idx, rk_out, exp_rk[5]);
    end
    rk_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_idx !== 4'd0 || rk_out !== 128'h0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b busy=%b done=%b idx=%0d out=%h want all 0", rk_valid, busy, done, rk_idx, rk_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_idle: got valid=%b busy=%b idx=%0d want 0 0 0", rk_valid, busy, rk_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nk  = {$urandom, $urandom, $urandom, $urandom};
    launch(nk);
    drain(100, 1'b0, 1'b0, '0);
    check_idle_after();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka;
    logic [127:0] kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model_expand(ka);
    start  = 1'b1;
    key_in = ka;
    @(negedge clk);
    key_in = kb;
    drain(100, 1'b0, 1'b1, kb);
    model_expand(kb);
    @(negedge clk);
    drain(100, 1'b0, 1'b0, '0);
    check_idle_after();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
